// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Iterative signed 32x32 multiply and signed 32/32 divide unit for a
// pipelined CPU. One operation takes 32 iteration cycles followed by a
// single DONE cycle in which the result is presented.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   ctrl_MULT       start signed multiply (wins over ctrl_DIV)
//   ctrl_DIV        start signed divide
//   data_operandA   multiplicand / dividend, latched at the accepting edge
//   data_operandB   multiplier / divisor, latched at the accepting edge
//   data_result     product low word / quotient, held until the next DONE
//   data_exception  overflow or divide-by-zero flag for data_result
//   data_resultRDY  high only in the DONE cycle
//   stall           holds the front of the pipeline while the unit is busy
//   dbg_state       current FSM state (IDLE=0, MULT=1, DIV=2, DONE=3)
//
// Handshake: a start (ctrl_MULT/ctrl_DIV) is accepted at a rising edge only
// while the FSM is in IDLE or DONE; requests seen in MULT/DIV are dropped.
// stall goes high combinationally in the requesting cycle and stays high
// until the last iteration cycle. data_resultRDY is a one-cycle pulse that
// qualifies data_result/data_exception; it has no back-pressure.

module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             stall,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'd31;

    state_t             state, next_state;
    logic [4:0]         count;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;     // |multiplicand| or |divisor|
    logic               neg;         // result sign after magnitude math
    logic               div_zero;

    logic               start_ok, start_mult, start_div, last_iter;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next, mult_signed;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_signed;
    logic               mult_ovf, div_exc;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state     = state;
        start_ok       = (state == S_IDLE) || (state == S_DONE);
        start_mult     = start_ok && ctrl_MULT;
        start_div      = start_ok && ctrl_DIV && !ctrl_MULT;
        last_iter      = (count == CNT_LAST);
        stall          = (state == S_MULT) || (state == S_DIV) ||
                         (start_ok && (ctrl_MULT || ctrl_DIV));
        data_resultRDY = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start_mult)     next_state = S_MULT;
                else if (start_div) next_state = S_DIV;
                else                next_state = S_IDLE;
            end
            S_MULT, S_DIV: begin
                if (last_iter) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    // ---------------- datapath ----------------
    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        // Shift-add step on magnitudes; 2^31 fits as an unsigned magnitude.
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        mult_next = {mult_sum, acc[WIDTH-1:1]};
        mult_signed = neg ? -mult_next : mult_next;
        // Overflow when the upper word plus bit 31 are not all equal.
        mult_ovf  = !((&mult_signed[2*WIDTH-1:WIDTH-1]) ||
                      !(|mult_signed[2*WIDTH-1:WIDTH-1]));

        // Restoring divide step; remainder < divisor so rem_sh fits W+1 bits.
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        if (!diff[WIDTH]) div_next = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
        else              div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        quo_signed = neg ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        // A positive quotient with bit 31 set can only be 0x80000000 / -1.
        div_exc    = div_zero || (!neg && div_next[WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            acc            <= '0;
            operand        <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mult || start_div) begin
            count    <= '0;
            acc      <= {{WIDTH{1'b0}}, (start_mult ? abs_b : abs_a)};
            operand  <= start_mult ? abs_a : abs_b;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
        end else if (state == S_MULT) begin
            count <= count + 5'd1;
            acc   <= mult_next;
            if (last_iter) begin
                data_result    <= mult_signed[WIDTH-1:0];
                data_exception <= mult_ovf;
            end
        end else if (state == S_DIV) begin
            count <= count + 5'd1;
            acc   <= div_next;
            if (last_iter) begin
                data_result    <= div_zero ? '0 : quo_signed;
                data_exception <= div_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Testbench for multdiv_sequencer: directed vectors with hand-computed
// results, a scoreboard queue of expected {exception, result} and the cycle
// in which data_resultRDY must appear, and a monitor that pops on every
// data_resultRDY pulse.

module tb_multdiv_sequencer;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, stall;
    logic [1:0]  dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];       // {exception, result}
    int          exp_cyc_q[$];   // cycle in which RDY must be seen
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: got rdy=1 expected no result (cycle %0d)", cyc);
            end else begin
                logic [32:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("result",    data_result,             e[31:0]);
                check("exception", 32'(data_exception),     32'(e[32]));
                check("latency",   32'(cyc),                32'(ec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; drives a start for one cycle, then scrambles the
    // operands so a design that fails to latch them gives wrong results.
    task automatic issue(input bit do_mult, input bit do_div,
                         input logic [31:0] opa, input logic [31:0] opb,
                         input logic [32:0] exp, input bit expect_done);
        ctrl_MULT     = do_mult;
        ctrl_DIV      = do_div;
        data_operandA = opa;
        data_operandB = opb;
        if (expect_done) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + 33);
        end
        #1 check("stall_on_start", 32'(stall), 32'd1);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic mult(input logic [31:0] opa, input logic [31:0] opb,
                        input logic [32:0] exp);
        issue(1'b1, 1'b0, opa, opb, exp, 1'b1);
        wait_drain();
    endtask

    task automatic div(input logic [31:0] opa, input logic [31:0] opb,
                       input logic [32:0] exp);
        issue(1'b0, 1'b1, opa, opb, exp, 1'b1);
        wait_drain();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);

        // Reset state.
        check("rst_result",    data_result,           32'd0);
        check("rst_exception", 32'(data_exception),   32'd0);
        check("rst_rdy",       32'(data_resultRDY),   32'd0);
        check("rst_stall",     32'(stall),            32'd0);
        check("rst_state",     32'(dbg_state),        32'd0);

        // Reset wins over a simultaneous start.
        ctrl_MULT = 1'b1;
        @(negedge clock);
        check("rst_priority_state", 32'(dbg_state), 32'd0);
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        @(negedge clock);

        // 7 * 6 with stall / RDY timing and result hold.
        issue(1'b1, 1'b0, 32'd7, 32'd6, {1'b0, 32'd42}, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            check("stall_busy", 32'(stall),          32'd1);
            check("rdy_busy",   32'(data_resultRDY), 32'd0);
            @(negedge clock);
        end
        check("stall_done", 32'(stall), 32'd0);
        repeat (3) @(negedge clock);
        check("hold_result", data_result,         32'd42);
        check("hold_rdy",    32'(data_resultRDY), 32'd0);
        check("idle_stall",  32'(stall),          32'd0);
        wait_drain();

        // Divide vectors.
        div(32'hFFFF_FFF4, 32'd5,        {1'b0, 32'hFFFF_FFFE});  // -12/5 = -2
        div(32'd100,       32'd0,        {1'b1, 32'd0});          // /0
        div(32'h8000_0000, 32'hFFFF_FFFF, {1'b1, 32'h8000_0000}); // overflow
        div(32'd7,         32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD}); // 7/-2 = -3
        div(32'hFFFF_FFF9, 32'hFFFF_FFFE, {1'b0, 32'd3});         // -7/-2 = 3

        // Multiply vectors.
        mult(32'h0001_0000, 32'h0001_0000, {1'b1, 32'd0});          // 2^32
        mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'd1});          // -1*-1
        mult(32'h7FFF_FFFF, 32'd2,         {1'b1, 32'hFFFF_FFFE});  // +ovf
        mult(32'h8000_0000, 32'd1,         {1'b0, 32'h8000_0000});  // -2^31

        // Both starts high: multiply wins (5 * -4 = -20).
        issue(1'b1, 1'b1, 32'd5, 32'hFFFF_FFFC, {1'b0, 32'hFFFF_FFEC}, 1'b1);
        wait_drain();

        // Reset in cycle 10 of a multiply aborts it silently.
        issue(1'b1, 1'b0, 32'd3, 32'd3, 33'd0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_rdy",    32'(data_resultRDY), 32'd0);
        check("abort_stall",  32'(stall),          32'd0);
        check("abort_state",  32'(dbg_state),      32'd0);
        check("abort_result", data_result,         32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        div(32'd20, 32'd4, {1'b0, 32'd5});

        // DIV request mid-multiply is ignored; start in DONE is accepted.
        issue(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD, {1'b0, 32'hFFFF_F448}, 1'b1);
        repeat (4) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (27) @(negedge clock);
        check("done_state", 32'(dbg_state), 32'd3);
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFD}, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: ctrl_MULT  input  1  start signed multiply, sampled at rising edge.
REQ-005 SHALL have port: ctrl_DIV  input  1  start signed divide, sampled at rising edge.
REQ-006 SHALL have port: data_operandA  input  32  multiplicand / dividend.
REQ-007 SHALL have port: data_operandB  input  32  multiplier / divisor.
REQ-008 SHALL have port: data_result  output  32  product low word / quotient.
REQ-009 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag for data_result.
REQ-010 SHALL have port: data_resultRDY  output  1  one-cycle pulse when result and exception are valid.
REQ-011 SHALL have port: stall  output  1  freezes PC and the F/D and D/X pipeline latches while the unit is occupied.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE plus a 5-bit iteration counter.
REQ-013 SHALL accept a start only in IDLE or DONE; start requests in MULT or DIV are ignored.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are both high.
REQ-015 SHALL latch data_operandA and data_operandB at the accepting edge; later operand changes have no effect on the operation.
REQ-016 SHALL clear the counter on an accepted start and increment it each cycle in MULT/DIV.
REQ-017 SHALL move MULT/DIV -> DONE on the edge where the counter equals 31, giving 32 iteration cycles.
REQ-018 SHALL move DONE -> IDLE when no start is present, and DONE -> MULT/DIV on a start (back-to-back).
REQ-019 SHALL hold data_resultRDY high only in DONE: the 33rd cycle after the accepting edge.
REQ-020 SHALL drive stall = (state is MULT or DIV) OR (state is IDLE or DONE AND (ctrl_MULT OR ctrl_DIV)); stall is low in DONE without a new start.
REQ-021 Multiply SHALL be a signed 32x32 iterative (radix-2 Booth or shift-add) producing a 64-bit product; data_result is the low 32 bits.
REQ-022 Multiply SHALL set data_exception=1 iff the 64-bit product is not the sign-extension of its low 32 bits.
REQ-023 Divide SHALL be a signed iterative restoring/non-restoring divide; the quotient truncates toward zero and the remainder is discarded.
REQ-024 On divide with divisor 0: data_result=0 and data_exception=1, with the normal 33-cycle latency.
REQ-025 On divide 0x80000000 / 0xFFFFFFFF: data_result=0x80000000 and data_exception=1.
REQ-026 SHALL hold data_result and data_exception from the DONE cycle until the next operation reaches DONE; they SHALL NOT change mid-operation.

Reset
REQ-027 With reset high at a rising edge, SHALL set state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0; stall SHALL be 0 the following cycle.
REQ-028 Reset during MULT/DIV SHALL abort the operation with no data_resultRDY pulse.
REQ-029 Reset SHALL take priority over a simultaneous ctrl_MULT/ctrl_DIV.

Verification
REQ-030 ctrl_MULT pulse, A=7, B=6 -> stall high for cycles 0..32, data_resultRDY only in cycle 33, data_result=42, data_exception=0.
REQ-031 ctrl_DIV, A=-12 (0xFFFFFFF4), B=5 -> data_result=0xFFFFFFFE, data_exception=0 at cycle 33.
REQ-032 ctrl_DIV, A=100, B=0 -> data_result=0, data_exception=1 at cycle 33.
REQ-033 ctrl_MULT, A=B=0x00010000 -> data_result=0, data_exception=1; ctrl_MULT, A=B=0xFFFFFFFF -> data_result=1, data_exception=0.
REQ-034 Reset asserted at cycle 10 of a multiply -> no data_resultRDY and stall=0; then ctrl_DIV, A=20, B=4 -> data_result=5 at cycle 33.
REQ-035 ctrl_DIV asserted during cycle 5 of a multiply -> ignored, product delivered unchanged; start in the DONE cycle -> accepted, second result at DONE+33.
